tb_status_responder: RTL

TB_STATUS_RESPONDER -- requirements
Module: tb_status_responder

---
 rtl/tb_status_pkg.sv | 42 ++++
 rtl/tb_status_fifo.sv | 58 +++++
 rtl/tb_status_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tb_status_pkg.sv
// Shared constants and types for the test-bench status responder.
package tb_status_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned STATUS_LVL_W = 6;

  // Register offsets relative to the window base
  localparam logic [ADDR_W-1:0] OFF_STDOUT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] OFF_PASS   = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] OFF_FAIL   = 32'h0000_0008;
  localparam logic [ADDR_W-1:0] OFF_EXIT   = 32'h0000_000C;
  localparam logic [ADDR_W-1:0] OFF_CYCLE  = 32'h0000_0010;
  localparam logic [ADDR_W-1:0] OFF_STATUS = 32'h0000_0014;

  localparam logic [DATA_W-1:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_PASS = 2'd1,
    CAUSE_FAIL = 2'd2,
    CAUSE_EXIT = 2'd3
  } cause_e;

  // Map a terminal-register offset to the end-of-test cause it signals
  function automatic cause_e cause_of(input logic [ADDR_W-1:0] off);
    cause_e c;
    c = CAUSE_NONE;
    if (off == OFF_PASS)      c = CAUSE_PASS;
    else if (off == OFF_FAIL) c = CAUSE_FAIL;
    else if (off == OFF_EXIT) c = CAUSE_EXIT;
    return c;
  endfunction

endpackage

// File: rtl/tb_status_fifo.sv
// Small synchronous FIFO for the stdout byte stream; head is visible on rdata_o.
module tb_status_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_level == LVL_W'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign rdata_o = r_mem[r_rptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Storage array; contents need no reset because pointers define validity
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tb_status_responder.sv
// Memory-mapped end-of-test responder: stdout FIFO, cycle counter, pass/fail/exit latch.
module tb_status_responder
  import tb_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PAD_W = DATA_W - 2 - STATUS_LVL_W;

  state_e              r_state;
  state_e              w_state_next;
  cause_e              r_cause;
  cause_e              w_cause_next;
  logic [DATA_W-1:0]   r_cycle;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_exit_value;
  logic                r_passed;
  logic                r_failed;
  logic                r_exited;

  logic [ADDR_W-1:0]   w_offset;
  logic                w_stdout_wr;
  logic                w_term_wr;
  logic                w_stall;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [LVL_W-1:0]    w_level;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_exit_load;
  logic                w_unused_be;

  assign w_unused_be = ^data_be_i[3:1];

  assign w_offset    = data_addr_i - BASE_ADDR;
  assign w_stdout_wr = data_req_i && data_we_i && (w_offset == OFF_STDOUT);
  assign w_pop       = !w_empty && char_ready_i;

  // Only a RUN-state stdout write into a full FIFO with no pop is back-pressured
  assign w_stall    = (r_state == ST_RUN) && w_stdout_wr && w_full && !w_pop;
  assign data_gnt_o = data_req_i && !w_stall;

  assign w_push    = data_gnt_o && w_stdout_wr && data_be_i[0] && (r_state == ST_RUN);
  assign w_term_wr = data_gnt_o && data_we_i &&
                     ((w_offset == OFF_PASS) || (w_offset == OFF_FAIL) || (w_offset == OFF_EXIT));
  assign w_exit_load = (r_state == ST_RUN) && w_term_wr && (w_offset == OFF_EXIT);

  tb_status_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (data_wdata_i[CHAR_W-1:0]),
    .rdata_o (char_o),
    .level_o (w_level),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign char_valid_o = !w_empty;

  // Read-data mux for the current request; writes always answer zero
  always_comb begin
    w_rdata = '0;
    if (!data_we_i) begin
      case (w_offset)
        OFF_CYCLE:  w_rdata = r_cycle;
        OFF_STATUS: w_rdata = {PAD_W'(0), r_state, STATUS_LVL_W'(w_level)};
        default:    w_rdata = RDATA_UNMAPPED;
      endcase
    end
  end

  // FSM state and cause registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
    end
  end

  // Next-state: first terminal write in RUN wins, then wait for stdout to drain
  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    case (r_state)
      ST_RUN: begin
        if (w_term_wr) begin
          w_state_next = ST_DRAIN;
          w_cause_next = cause_of(w_offset);
        end
      end
      ST_DRAIN: begin
        if (w_empty) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Bus response, cycle counter and end-of-test output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_cycle      <= '0;
      r_exit_value <= '0;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exited     <= 1'b0;
    end else begin
      r_rvalid <= data_gnt_o;
      r_rdata  <= data_gnt_o ? w_rdata : '0;
      r_cycle  <= r_cycle + DATA_W'(1);
      if (w_exit_load) r_exit_value <= data_wdata_i;
      r_passed <= (w_state_next == ST_DONE) && (w_cause_next == CAUSE_PASS);
      r_failed <= (w_state_next == ST_DONE) && (w_cause_next == CAUSE_FAIL);
      r_exited <= (w_state_next == ST_DONE) && (w_cause_next == CAUSE_EXIT);
    end
  end

  assign data_rvalid_o  = r_rvalid;
  assign data_rdata_o   = r_rdata;
  assign exit_value_o   = r_exit_value;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exited;

endmodule
